// File: rtl/bcd_window_if.sv
// Bus between the multiplier datapath / buttons and the BCD window converter.
// The master side drives the request and scroll pulses; the slave is the converter.
interface bcd_window_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] product;
  logic             start;
  logic             scroll_left;
  logic             scroll_right;
  logic             sign;
  logic [3:0]       BCD0;
  logic [3:0]       BCD1;
  logic [3:0]       BCD2;
  logic [1:0]       window;
  logic             busy;
  logic             done;

  modport master (
    output product,
    output start,
    output scroll_left,
    output scroll_right,
    input  sign,
    input  BCD0,
    input  BCD1,
    input  BCD2,
    input  window,
    input  busy,
    input  done
  );

  modport slave (
    input  product,
    input  start,
    input  scroll_left,
    input  scroll_right,
    output sign,
    output BCD0,
    output BCD1,
    output BCD2,
    output window,
    output busy,
    output done
  );
endinterface

// File: rtl/bcd_window_converter.sv
// Signed binary to BCD via iterative double-dabble, presenting a
// scrollable window of digits plus sign to the seven-segment driver.
module bcd_window_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int WIN    = 3
) (
  input logic         clk,
  input logic         rst,
  bcd_window_if.slave bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] WMAX = 2'(DIGITS - WIN);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic          load;
  logic          step;
  logic          fin;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] prod;
  logic [SW-1:0] scr_q;
  logic [SW-1:0] scr_adj;
  logic [SW+WIDTH-1:0] shifted;
  logic          neg_q;
  logic          nz_q;
  logic [SW-1:0] dig_q;
  logic          sign_q;
  logic [1:0]    win_q;
  logic          done_q;
  logic [4:0]    base0;
  logic [4:0]    base1;
  logic [4:0]    base2;

  assign prod  = bus.product;
  assign mag_d = prod[WIDTH-1] ? (~prod + WIDTH'(1)) : prod;

  // Correct every nibble that would overflow past 9 on the next shift.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {scr_adj, mag_q} << 1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FINISH;
      end
      FINISH: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mag_q <= '0;
      scr_q <= '0;
      neg_q <= 1'b0;
      nz_q  <= 1'b0;
    end else if (load) begin
      cnt_q <= '0;
      mag_q <= mag_d;
      scr_q <= '0;
      neg_q <= prod[WIDTH-1];
      nz_q  <= |prod;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      {scr_q, mag_q} <= shifted;
    end
  end

  // Display registers only change on FINISH, so partial results never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q  <= '0;
      sign_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        dig_q  <= scr_q;
        sign_q <= neg_q & nz_q;
      end
    end
  end

  // A completed conversion recentres the window, overriding any scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (fin) begin
      win_q <= '0;
    end else if (bus.scroll_left && !bus.scroll_right) begin
      if (win_q < WMAX)
        win_q <= win_q + 2'd1;
    end else if (bus.scroll_right && !bus.scroll_left) begin
      if (win_q != 2'd0)
        win_q <= win_q - 2'd1;
    end
  end

  assign base0 = {1'b0, win_q, 2'b00};
  assign base1 = base0 + 5'd4;
  assign base2 = base0 + 5'd8;

  assign bus.BCD0   = dig_q[base0 +: 4];
  assign bus.BCD1   = dig_q[base1 +: 4];
  assign bus.BCD2   = dig_q[base2 +: 4];
  assign bus.sign   = sign_q;
  assign bus.window = win_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_window_converter.sv
// Scoreboard bench for bcd_window_converter: directed conversions,
// window scrolling, ignored starts and asynchronous reset abort.
module tb_bcd_window_converter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_window_if #(.WIDTH(16)) bus ();

  bcd_window_converter #(
    .WIDTH (16),
    .DIGITS(5),
    .WIN   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       s;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done want none");
      end else begin
        e = q.pop_front();
        if ({bus.sign, bus.BCD2, bus.BCD1, bus.BCD0, bus.window} !==
            {e.s, e.d2, e.d1, e.d0, 2'b00}) begin
          n_bad++;
          $display("FAIL result: got s%0b %0h%0h%0h w%0d want s%0b %0h%0h%0h w0",
                   bus.sign, bus.BCD2, bus.BCD1, bus.BCD0, bus.window,
                   e.s, e.d2, e.d1, e.d0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scroll(input logic l, input logic r);
    bus.scroll_left  = l;
    bus.scroll_right = r;
    tick();
    bus.scroll_left  = 1'b0;
    bus.scroll_right = 1'b0;
  endtask

  task automatic chkwin(input string name, input logic [1:0] w,
                        input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0);
    chk(name, {18'd0, bus.window, bus.BCD2, bus.BCD1, bus.BCD0},
        {18'd0, w, d2, d1, d0});
  endtask

  task automatic run(input logic [15:0] prod, input logic s,
                     input logic [3:0] d2, input logic [3:0] d1,
                     input logic [3:0] d0, input int inj_at,
                     input int sc_at);
    int lat;
    int bc;
    exp_t e;
    e.s  = s;
    e.d2 = d2;
    e.d1 = d1;
    e.d0 = d0;
    q.push_back(e);
    bus.product = prod;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bc++;
      if (lat == inj_at) begin
        bus.product = 16'h0001;
        bus.start   = 1'b1;
      end
      if (lat == sc_at) bus.scroll_left = 1'b1;
      tick();
      bus.start       = 1'b0;
      bus.scroll_left = 1'b0;
      lat++;
    end
    chk("latency", lat, 17);
    chk("busy_cycles", bc, 17);
    tick();
    chk("busy_after", {31'd0, bus.busy}, 0);
  endtask

  initial begin
    int nd;
    rst              = 1'b1;
    bus.product      = '0;
    bus.start        = 1'b0;
    bus.scroll_left  = 1'b0;
    bus.scroll_right = 1'b0;
    tick();
    tick();
    chk("reset_outs",
        {bus.sign, bus.BCD2, bus.BCD1, bus.BCD0, bus.window, bus.busy, bus.done},
        0);
    rst = 1'b0;
    tick();

    run(16'h0000, 1'b0, 4'd0, 4'd0, 4'd0, -1, -1);

    run(16'h4000, 1'b0, 4'd3, 4'd8, 4'd4, -1, -1);
    scroll(1'b1, 1'b0);
    chkwin("scroll_l1", 2'd1, 4'd6, 4'd3, 4'd8);
    scroll(1'b1, 1'b0);
    chkwin("scroll_l2", 2'd2, 4'd1, 4'd6, 4'd3);
    scroll(1'b1, 1'b0);
    chkwin("scroll_l_sat", 2'd2, 4'd1, 4'd6, 4'd3);
    scroll(1'b0, 1'b1);
    chkwin("scroll_r1", 2'd1, 4'd6, 4'd3, 4'd8);
    scroll(1'b0, 1'b1);
    scroll(1'b0, 1'b1);
    chkwin("scroll_r_sat", 2'd0, 4'd3, 4'd8, 4'd4);

    run(16'h8000, 1'b1, 4'd7, 4'd6, 4'd8, -1, -1);
    run(16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd1, -1, -1);

    nd = n_done;
    run(16'h3039, 1'b0, 4'd3, 4'd4, 4'd5, 4, -1);
    repeat (25) tick();
    chk("ignored_start_dones", n_done - nd, 1);

    bus.product = 16'h3039;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("async_reset_outs",
        {bus.sign, bus.BCD2, bus.BCD1, bus.BCD0, bus.window, bus.busy, bus.done},
        0);
    #2;
    rst = 1'b0;
    nd  = n_done;
    repeat (25) tick();
    chk("abort_no_done", n_done - nd, 0);

    run(16'hFF85, 1'b1, 4'd1, 4'd2, 4'd3, -1, -1);

    run(16'h00FF, 1'b0, 4'd2, 4'd5, 4'd5, -1, 16);
    chk("finish_scroll_win", {30'd0, bus.window}, 0);
    scroll(1'b1, 1'b0);
    chkwin("scroll_255", 2'd1, 4'd0, 4'd2, 4'd5);
    scroll(1'b1, 1'b1);
    chkwin("scroll_both", 2'd1, 4'd0, 4'd2, 4'd5);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_window_converter.md
Name: bcd_window_converter

Overview:
Sequential signed-binary-to-BCD converter that feeds the seven-segment driver stage. It takes the 16-bit signed product from the multiplier datapath and converts its magnitude to 5 BCD digits with an iterative double-dabble FSM. It presents a 3-digit scrollable window (BCD0..BCD2) plus a sign bit, matching the driver's inputs. The window is moved by pre-debounced left/right button pulses.

Parameters:
WIDTH, 16, width of the signed two's-complement input
DIGITS, 5, number of BCD digits held internally (must cover 2^(WIDTH-1))
WIN, 3, number of digits presented on the output window

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
product  input  WIDTH  signed value to convert; sampled only on an accepted start
start  input  1  single-cycle request to convert product
scroll_left  input  1  single-cycle pulse; move window toward more-significant digits
scroll_right  input  1  single-cycle pulse; move window toward less-significant digits
sign  output  1  1 = displayed value is negative
BCD0  output  4  least-significant digit of window (digit[window])
BCD1  output  4  digit[window+1]
BCD2  output  4  digit[window+2]
window  output  2  current window offset, 0..DIGITS-WIN
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: new digits valid

Behaviour:
- Reset (async, rst=1): state IDLE; sign, BCD0..2, window, busy, done, all internal digit/shift registers = 0. Reset mid-conversion aborts it; no done pulse follows.
- States: IDLE, CONVERT, FINISH.
- IDLE: start=1 at edge k -> latch neg = product[WIDTH-1]; mag = |product| as unsigned WIDTH bits (-32768 -> 32768, no overflow); clear scratch BCD register; iteration count = 0; -> CONVERT. busy=1 from after edge k.
- CONVERT: one iteration per clock. Add 3 to every scratch nibble >= 5, then shift {scratch, mag} left by 1. After WIDTH iterations (edges k+1..k+16) -> FINISH.
- FINISH (edge k+17): copy scratch to output digit registers; sign = neg AND (mag != 0), so zero is never negative; window = 0; busy=0; done=1 for exactly the cycle after edge k+17; -> IDLE.
- Fixed latency: start to done = 17 clocks. Outputs keep their previous values until FINISH, so the display never shows partial results.
- start while busy (CONVERT/FINISH): ignored, not queued. start in the same cycle done is high is accepted, since the state is already IDLE.
- Window: BCDn = digit[window+n]. scroll_left: window+1, saturating at DIGITS-WIN (=2). scroll_right: window-1, saturating at 0. Both asserted together: no change. Scrolling is honoured in any state. The FINISH window reset takes priority over a same-cycle scroll.
- Output regs are the only source for BCD0..2 and sign. There is no combinational path from product.

Test Plan:
- Reset then product=16'h0000, start -> done 17 cycles later; BCD2/1/0=0/0/0, sign=0, window=0; busy high exactly 17 cycles.
- product=16'h4000 (16384) -> digits 1,6,3,8,4; window0 shows BCD2/1/0=3/8/4; scroll_left x1 -> 6/3/8; scroll_left x2 -> 1/6/3, window=2; 3rd scroll_left -> unchanged; scroll_right x3 -> back to 3/8/4, window=0 saturated.
- product=16'h8000 (-32768) -> sign=1, digits 3,2,7,6,8; product=16'hFFFF (-1) -> sign=1, BCD0=1, others 0.
- Start 12345 (16'h3039), pulse start again at cycle 5 with 16'h0001 -> second start ignored; result 12345 at cycle 17; no second done.
- Start 16'h3039, assert rst at cycle 8 -> all outputs 0 immediately (async), no done. Restart with 16'hFF85 (-123) -> sign=1, 1/2/3.
- scroll_left in the FINISH cycle -> window=0 after done (FINISH wins); simultaneous scroll_left+scroll_right -> window unchanged.
